tx: RTL and testbench

//  Parallel-to-serial flit transmitter, the upstream stage of rx on every router link.

---
 rtl/tx_pkg.sv | 29 ++
 rtl/tx_fifo.sv | 57 +++++
 rtl/tx.sv | 92 +++++++++
 tb/tb_tx.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// ============================================================================
// Module : tx_pkg
// Brief  : Shared item/frame types and widths for the serial link transmitter.
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

`ifndef SIZE
`define SIZE 8
`endif

package tx_pkg;

    localparam int ITEM_W  = `SIZE;
    localparam int FRAME_W = `SIZE + 2;
    localparam int CNT_W   = $clog2(`SIZE + 2);

    typedef logic [ITEM_W-1:0]  item_t;
    typedef logic [FRAME_W-1:0] frame_t;

    // Frame leaves LSB first: head 1, data LSB first, trailing 0.
    function automatic frame_t build_frame(input item_t item);
        return {1'b0, item, 1'b1};
    endfunction

endpackage

`default_nettype wire

// File: rtl/tx_fifo.sv
// ============================================================================
// Module : tx_fifo
// Brief  : DEPTH x item first-word-fallthrough FIFO, sync active-low reset.
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tx_fifo
    import tx_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  wr_en,
    input  item_t din,
    input  logic  rd_en,
    output item_t dout,
    output logic  full,
    output logic  empty
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    item_t       r_mem [DEPTH];
    logic        w_wr;
    logic        w_rd;

    assign w_wr = wr_en & ~full;
    assign w_rd = rd_en & ~empty;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

    assign dout  = r_mem[r_rd_ptr[AW-1:0]];
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

`default_nettype wire

// File: rtl/tx.sv
// ============================================================================
// Module : tx
// Brief  : Parallel-to-serial flit transmitter feeding the downstream rx link.
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tx
    import tx_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  valid_in,
    output logic  ready,
    input  item_t parallel_in,
    input  logic  channel_busy,
    output logic  serial_out,
    output logic  tx_active
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITEM_W + 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    frame_t           r_sh;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    item_t            w_head;

    assign ready  = reset & ~w_full;
    assign w_push = valid_in & ready;
    assign w_pop  = (r_state == ST_IDLE) & ~w_empty & ~channel_busy;

    tx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .wr_en (w_push),
        .din   (parallel_in),
        .rd_en (w_pop),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_sh    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_sh    <= build_frame(w_head);
                        r_cnt   <= '0;
                        r_state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // Counter holds at its last value so it never wraps.
                    r_sh <= r_sh >> 1;
                    if (r_cnt == LAST_CNT) begin
                        r_state <= ST_WAIT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (!channel_busy) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign serial_out = r_sh[0];
    assign tx_active  = (r_state == ST_SEND) | (r_state == ST_WAIT);

endmodule

`default_nettype wire

// File: tb/tb_tx.sv
// ============================================================================
// Module : tb_tx
// Brief  : Scoreboard bench for tx with a behavioural downstream rx.
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_tx;
    import tx_pkg::*;

    localparam int DEPTH = 2;

    logic  clk         = 1'b0;
    logic  reset       = 1'b0;
    logic  valid_in    = 1'b0;
    item_t parallel_in = '0;
    logic  channel_busy;
    logic  ready;
    logic  serial_out;
    logic  tx_active;

    logic  force_busy = 1'b0;
    logic  rand_busy  = 1'b0;
    int    rd_mode    = 1;
    logic  auto_rd    = 1'b0;
    logic  man_rd     = 1'b0;

    logic [1:0] rx_state = 2'd0;
    int         rx_bit   = 0;
    item_t      rx_data  = '0;
    logic       rx_valid = 1'b0;
    logic       rx_new   = 1'b0;
    logic       rx_trail = 1'b0;

    item_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    assign channel_busy = force_busy | rx_valid | (rx_state != 2'd0);

    tx #(
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .valid_in     (valid_in),
        .ready        (ready),
        .parallel_in  (parallel_in),
        .channel_busy (channel_busy),
        .serial_out   (serial_out),
        .tx_active    (tx_active)
    );

    // Downstream receiver: head bit, SIZE data bits LSB first, trailing bit.
    always @(posedge clk) begin
        if (!reset) begin
            rx_state <= 2'd0;
            rx_bit   <= 0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_new   <= 1'b0;
            rx_trail <= 1'b0;
        end else begin
            rx_new <= 1'b0;
            if ((auto_rd | man_rd) && rx_valid) rx_valid <= 1'b0;
            case (rx_state)
                2'd0: if (serial_out) begin
                    rx_state <= 2'd1;
                    rx_bit   <= 0;
                end
                2'd1: begin
                    rx_data[rx_bit] <= serial_out;
                    if (rx_bit == ITEM_W - 1) rx_state <= 2'd2;
                    else rx_bit <= rx_bit + 1;
                end
                default: begin
                    rx_trail <= serial_out;
                    rx_valid <= 1'b1;
                    rx_new   <= 1'b1;
                    rx_state <= 2'd0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        auto_rd = (rd_mode == 1) ? 1'b1 :
                  (rd_mode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
        if (rand_busy) force_busy = ($urandom_range(0, 9) == 0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin : mon
        item_t e;
        if (rx_new) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected actual=%0h required=none", rx_data);
            end else begin
                e = exp_q.pop_front();
                check("rx_item", 32'(rx_data), 32'(e));
            end
            check("rx_trailing", 32'(rx_trail), 32'd0);
        end
        if (reset) begin
            if (!tx_active) check("idle_serial", 32'(serial_out), 32'd0);
            if (rx_valid)   check("hold_serial", 32'(serial_out), 32'd0);
        end
    end

    task automatic enqueue(input item_t item);
        int n;
        n = 0;
        @(negedge clk);
        valid_in    = 1'b1;
        parallel_in = item;
        while (!ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL enqueue_timeout actual=ready0 required=ready1");
        end else begin
            @(posedge clk);
            exp_q.push_back(item);
        end
        #1 valid_in = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || rx_valid || tx_active) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_rx(input string name, input int budget);
        int n;
        n = 0;
        while (!rx_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(rx_valid), 32'd1);
    endtask

    initial begin : stim
        logic [9:0] pat;
        item_t      item;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_ready_low", 32'(ready), 32'd0);
        check("reset_serial", 32'(serial_out), 32'd0);
        check("reset_active", 32'(tx_active), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("reset_ready", 32'(ready), 32'd1);

        // Single frame 8'hA5: 1,1,0,1,0,0,1,0,1,0
        rd_mode = 1;
        pat = 10'b0101001011;
        enqueue(8'hA5);
        @(negedge clk);
        check("t1_pre", 32'(serial_out), 32'd0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("t1_bit", 32'(serial_out), 32'(pat[k]));
        end
        wait_drain("t1_drain", 100);

        // Back-to-back items with the receiver holding its item
        rd_mode = 0;
        enqueue(8'h01);
        enqueue(8'hFF);
        wait_rx("t2_first_valid", 100);
        repeat (4) @(negedge clk);
        check("t2_wait_active", 32'(tx_active), 32'd1);
        check("t2_wait_serial", 32'(serial_out), 32'd0);
        man_rd = 1'b1;
        @(posedge clk);
        #1 man_rd = 1'b0;
        @(negedge clk);
        check("t2_gap0", 32'(serial_out), 32'd0);
        @(negedge clk);
        check("t2_gap1", 32'(serial_out), 32'd0);
        @(negedge clk);
        check("t2_head", 32'(serial_out), 32'd1);
        wait_rx("t2_second_valid", 100);
        rd_mode = 1;
        wait_drain("t2_drain", 100);

        // Busy link: fill the FIFO, nothing leaves until release
        force_busy = 1'b1;
        enqueue(8'h11);
        enqueue(8'h22);
        @(negedge clk);
        check("t3_full_ready", 32'(ready), 32'd0);
        repeat (6) @(negedge clk);
        check("t3_serial", 32'(serial_out), 32'd0);
        check("t3_active", 32'(tx_active), 32'd0);
        force_busy = 1'b0;
        wait_drain("t3_drain", 200);

        // Enqueue held while full, accepted right after the pop edge
        force_busy = 1'b1;
        enqueue(8'h33);
        enqueue(8'h44);
        @(negedge clk);
        check("t5_full", 32'(ready), 32'd0);
        force_busy  = 1'b0;
        valid_in    = 1'b1;
        parallel_in = 8'h55;
        @(posedge clk);
        @(negedge clk);
        check("t5_ready_after_pop", 32'(ready), 32'd1);
        check("t5_active", 32'(tx_active), 32'd1);
        @(posedge clk);
        exp_q.push_back(8'h55);
        #1 valid_in = 1'b0;
        wait_drain("t5_drain", 200);

        // Reset during data bit 4 of a frame
        enqueue(8'h3C);
        @(negedge clk);
        repeat (6) @(negedge clk);
        check("t4_bit4", 32'(serial_out), 32'd1);
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("t4_rst_serial", 32'(serial_out), 32'd0);
        check("t4_rst_ready", 32'(ready), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("t4_post_serial", 32'(serial_out), 32'd0);
        check("t4_post_active", 32'(tx_active), 32'd0);
        check("t4_post_ready", 32'(ready), 32'd1);
        repeat (20) @(negedge clk);
        check("t4_no_rx", 32'(rx_valid), 32'd0);
        check("t4_quiet", 32'(serial_out), 32'd0);

        // Random items, random read-back and random busy pulses
        rd_mode   = 2;
        rand_busy = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            item = item_t'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            enqueue(item);
        end
        @(negedge clk);
        rand_busy  = 1'b0;
        force_busy = 1'b0;
        rd_mode    = 1;
        wait_drain("t6_drain", 500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
